// File: rtl/argmax_seq.sv
// argmax_seq
// Final classification stage of the ECG 1D-CNN. Accepts one frame of
// NUM_CLASS unsigned class scores over a valid/ready stream, shares a single
// strict greater-than comparator across the frame, and presents the winning
// class index and its score on a registered valid/ready result port.
//
// Ports:
//   i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//   i_start           frame start pulse, honoured only while idle
//   i_valid/o_ready   score stream handshake, i_data is the score
//   o_busy            high whenever a frame is in progress or a result is pending
//   o_valid/i_ready   result handshake, o_idx/o_max are the argmax and its score
module argmax_seq #(
  parameter int DW        = 32,
  parameter int NUM_CLASS = 5,
  parameter int IW        = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_busy,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [IW-1:0] o_idx,
  output logic [DW-1:0] o_max
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Count value of the final score in a frame; cnt is one bit wider than the
  // index so it never wraps inside a frame.
  localparam logic [IW:0] LAST_CNT = (IW+1)'(NUM_CLASS - 1);

  logic [1:0]    state_q, state_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] max_q, max_d;
  logic          xfer;

  assign o_ready = (state_q == LOAD) || (state_q == SCAN);
  assign o_busy  = (state_q != IDLE);
  assign o_valid = (state_q == DONE);
  assign o_idx   = idx_q;
  assign o_max   = max_q;

  assign xfer = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    max_d   = max_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          idx_d   = '0;
          max_d   = '0;
        end
      end
      LOAD: begin
        // The first score seeds the running maximum without a compare.
        if (xfer) begin
          max_d   = i_data;
          idx_d   = '0;
          cnt_d   = (IW+1)'(1);
          state_d = (NUM_CLASS == 1) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (xfer) begin
          // Strict compare: on a tie the earlier index is kept.
          if (i_data > max_q) begin
            max_d = i_data;
            idx_d = cnt_q[IW-1:0];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
    end
  end

endmodule

// File: tb/tb_argmax_seq.sv
// Self-checking bench for argmax_seq: a 5-class build and a 1-class build.
module tb_argmax_seq;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, valid, ready_in;
  logic [DW-1:0] data;
  logic          ready_out, busy, res_valid;
  logic [2:0]    idx;
  logic [DW-1:0] maxv;

  logic          s_start, s_valid, s_ready_in;
  logic [DW-1:0] s_data;
  logic          s_ready_out, s_busy, s_res_valid;
  logic [0:0]    s_idx;
  logic [DW-1:0] s_maxv;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2+DW:0] sb[$];
  logic [2:0]    exp_idx;
  logic [DW-1:0] exp_max;
  bit            have_exp;

  always #5 clk = ~clk;

  argmax_seq #(.DW(DW), .NUM_CLASS(5), .IW(3)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
    .o_ready(ready_out), .i_data(data), .o_busy(busy), .o_valid(res_valid),
    .i_ready(ready_in), .o_idx(idx), .o_max(maxv)
  );

  argmax_seq #(.DW(DW), .NUM_CLASS(1), .IW(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_valid(s_valid),
    .o_ready(s_ready_out), .i_data(s_data), .o_busy(s_busy), .o_valid(s_res_valid),
    .i_ready(s_ready_in), .o_idx(s_idx), .o_max(s_maxv)
  );

  // Reference argmax over a frame: strictly greater wins, ties keep earliest.
  function automatic logic [2+DW:0] model(input logic [DW-1:0] sc[5], input int n);
    logic [DW-1:0] m;
    logic [2:0]    k;
    m = sc[0];
    k = 3'd0;
    for (int i = 1; i < n; i++) begin
      if (sc[i] > m) begin
        m = sc[i];
        k = 3'(i);
      end
    end
    return {k, m};
  endfunction

  task automatic pop_expected();
    if (sb.size() == 0) begin
      have_exp = 1'b0;
      exp_idx  = '0;
      exp_max  = '0;
    end else begin
      have_exp = 1'b1;
      {exp_idx, exp_max} = sb.pop_front();
    end
  endtask

  // Start pulse then the five scores, gap idle cycles before each score.
  // Returns with the last score transferred and the sample point reached.
  task automatic drive_frame(input logic [DW-1:0] sc[5], input int gap);
    sb.push_back(model(sc, 5));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g < gap; g++) begin
        valid = 1'b0;
        data  = 32'hDEAD_BEEF;
        @(negedge clk);
      end
      valid = 1'b1;
      data  = sc[i];
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic check_result(input string name);
    pop_expected();
    n_cmp++;
    if (!have_exp) begin
      n_bad++;
      $display("[TB] FAIL %s scoreboard empty", name);
    end
    n_cmp++;
    if (res_valid !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL %s o_valid got %b want 1", name, res_valid);
    end
    n_cmp++;
    if (idx !== exp_idx) begin
      n_bad++;
      $display("[TB] FAIL %s o_idx got %0d want %0d", name, idx, exp_idx);
    end
    n_cmp++;
    if (maxv !== exp_max) begin
      n_bad++;
      $display("[TB] FAIL %s o_max got %h want %h", name, maxv, exp_max);
    end
  endtask

  task automatic accept_result(input string name);
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL %s after accept valid=%b busy=%b want 0 0", name, res_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_cmp++;
    if ({ready_out, busy, res_valid} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL reset ready/busy/valid got %b want 000", {ready_out, busy, res_valid});
    end
    n_cmp++;
    if (idx !== 3'd0 || maxv !== 32'd0) begin
      n_bad++;
      $display("[TB] FAIL reset idx/max got %0d/%h want 0/0", idx, maxv);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] sc[5] = '{32'd3, 32'd9, 32'd2, 32'd9, 32'd4};
    sb.push_back(model(sc, 5));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (ready_out !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL start_latency ready/busy got %b%b want 11", ready_out, busy);
    end
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      data  = sc[i];
      @(negedge clk);
      if (i < 4) begin
        n_cmp++;
        if (res_valid !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL basic_early_valid at score %0d got %b want 0", i, res_valid);
        end
      end
    end
    valid = 1'b0;
    n_cmp++;
    if (ready_out !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL basic_done_ready got %b want 0", ready_out);
    end
    check_result("basic");
    accept_result("basic");
  endtask

  task automatic test_extremes();
    logic [DW-1:0] a[5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFF_FFFF};
    logic [DW-1:0] b[5] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd7};
    drive_frame(a, 0);
    check_result("extreme_max");
    accept_result("extreme_max");
    drive_frame(b, 0);
    check_result("all_equal");
    accept_result("all_equal");
  endtask

  task automatic test_bubbles();
    logic [DW-1:0] sc[5] = '{32'd3, 32'd9, 32'd2, 32'd9, 32'd4};
    drive_frame(sc, 2);
    check_result("bubbles");
    accept_result("bubbles");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a[5] = '{32'd10, 32'd30, 32'd20, 32'd5, 32'd30};
    logic [DW-1:0] b[5] = '{32'd0, 32'd0, 32'd5, 32'd0, 32'd0};
    drive_frame(a, 0);
    pop_expected();
    for (int c = 0; c < 3; c++) begin
      start = (c == 1);
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b1 || ready_out !== 1'b0 || idx !== exp_idx || maxv !== exp_max) begin
        n_bad++;
        $display("[TB] FAIL hold cycle %0d valid=%b ready=%b idx=%0d max=%h want 1 0 %0d %h",
                 c, res_valid, ready_out, idx, maxv, exp_idx, exp_max);
      end
    end
    start = 1'b0;
    accept_result("backpressure");
    drive_frame(b, 0);
    check_result("after_backpressure");
    accept_result("after_backpressure");
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] sc[5] = '{32'd1, 32'd8, 32'd3, 32'd2, 32'd6};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b1;
    data  = 32'd50;
    @(negedge clk);
    data  = 32'd70;
    @(negedge clk);
    valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ready_out, busy, res_valid} !== 3'b000 || idx !== 3'd0 || maxv !== 32'd0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset ready/busy/valid=%b idx=%0d max=%h want 000 0 0",
               {ready_out, busy, res_valid}, idx, maxv);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_frame(sc, 0);
    check_result("after_reset");
    accept_result("after_reset");
  endtask

  task automatic test_single_class();
    logic [DW-1:0] sc[5] = '{32'd42, 32'd0, 32'd0, 32'd0, 32'd0};
    sb.push_back(model(sc, 1));
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'd42;
    @(negedge clk);
    s_valid = 1'b0;
    pop_expected();
    n_cmp++;
    if (!have_exp || s_res_valid !== 1'b1 || {2'b00, s_idx} !== exp_idx || s_maxv !== exp_max) begin
      n_bad++;
      $display("[TB] FAIL single_class valid=%b idx=%0d max=%h want 1 %0d %h",
               s_res_valid, s_idx, s_maxv, exp_idx, exp_max);
    end
    s_ready_in = 1'b1;
    @(negedge clk);
    s_ready_in = 1'b0;
    n_cmp++;
    if (s_busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL single_class_idle busy got %b want 0", s_busy);
    end
  endtask

  initial begin
    start = 0; valid = 0; ready_in = 0; data = '0;
    s_start = 0; s_valid = 0; s_ready_in = 0; s_data = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_bubbles();
    test_backpressure();
    test_reset_mid();
    test_single_class();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/argmax_seq.md
# argmax_seq

Sequencing controller for the final classification stage of the ECG 1D-CNN. It accepts one frame of `NUM_CLASS` class scores over a valid/ready stream and time-shares a single strict unsigned greater-than comparator across the frame. It tracks the running maximum and its index, then presents the winning class index and score on a registered valid/ready result port. It sits between the last dense layer output and the host/result interface.

## Interface
- `DW`, 32, score width in bits; scores are unsigned.
- `NUM_CLASS`, 5, scores per frame; legal range 1..2^IW.
- `IW`, 3, index width; must satisfy 2^IW >= NUM_CLASS.

- `i_clk`  in  1  sole clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  frame start pulse; honoured only in IDLE.
- `i_valid`  in  1  score valid.
- `o_ready`  out  1  score ready; a score transfers when `i_valid && o_ready`.
- `i_data`  in  DW  class score.
- `o_busy`  out  1  high in every state except IDLE.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  result accepted by the consumer.
- `o_idx`  out  IW  argmax class index.
- `o_max`  out  DW  maximum score.

## Operation
- The FSM has four states: IDLE, LOAD, SCAN, DONE. All outputs are registered or decoded from the state.
- **IDLE**
  - `o_ready`=0, `o_valid`=0.
  - `i_start`=1 → LOAD; clear `o_max`, `o_idx` and the counter `cnt` to 0.
- **LOAD**
  - `o_ready`=1.
  - On transfer: `o_max`←`i_data`, `o_idx`←0, `cnt`←1 (no compare is made).
  - Next state is DONE if `NUM_CLASS`==1, otherwise SCAN.
- **SCAN**
  - `o_ready`=1.
  - On transfer: if `i_data` > `o_max` (strict, unsigned), then `o_max`←`i_data` and `o_idx`←`cnt`.
  - `cnt`←`cnt`+1.
  - If `cnt`==`NUM_CLASS`-1 at the transfer → DONE.
- **DONE**
  - `o_ready`=0, `o_valid`=1; `o_idx` and `o_max` are held stable.
  - `i_ready`=1 → IDLE.
- Ties keep the earliest index, because the compare is strictly greater-than.
- `i_start` is ignored outside IDLE. No queuing; no error flag.
- `i_valid` is ignored in IDLE and DONE. The `cnt` width is IW+1 bits, so no wrap-around occurs inside a frame.
- `i_rst`=1 at any time, including mid-frame, forces IDLE and clears `cnt`. The partial frame is discarded.

## Timing
- Reset values: `o_ready`=0, `o_busy`=0, `o_valid`=0, `o_idx`=0, `o_max`=0.
- `i_start` sampled at edge T → LOAD from T+1, so `o_ready`=1 in cycle T+1.
- Throughput is one score per cycle. With no bubbles, `o_valid` rises the cycle after the last score transfer.
  - The minimum frame is 1 start cycle + `NUM_CLASS` transfer cycles, with `o_valid` in the following cycle.
- Result handshake: `o_valid` stays high until `i_ready` is sampled high.
  - The FSM is in IDLE the next cycle.
  - A new `i_start` is honoured at the earliest one cycle after the result handshake.
- Input bubbles (`i_valid`=0) stall the FSM with no change to state or registers.
- The compare path is combinational on `i_data` vs `o_max`, with a single registered update per transfer.

## Test plan
- Basic frame, `NUM_CLASS`=5, back-to-back scores 3, 9, 2, 9, 4 → `o_valid` one cycle after the 5th transfer, `o_idx`=1, `o_max`=9 (tie keeps first).
- Unsigned extremes: 1, 2, 3, 4, 0xFFFFFFFF → `o_idx`=4, `o_max`=0xFFFFFFFF. All-equal frame 7, 7, 7, 7, 7 → `o_idx`=0, `o_max`=7.
- Input bubbles: the basic frame with `i_valid` low for 2 cycles between each score → identical result, with `o_valid` rising one cycle after the last transfer.
- Output backpressure: hold `i_ready`=0 for 3 cycles in DONE and pulse `i_start` → `o_valid`, `o_idx` and `o_max` held, `o_ready`=0, start ignored. After `i_ready`=1 → IDLE, then a new frame 0, 0, 5, 0, 0 gives `o_idx`=2.
- Reset mid-frame: assert `i_rst` asynchronously after 2 transfers → all outputs 0 immediately and IDLE. A following full frame 1, 8, 3, 2, 6 gives `o_idx`=1, `o_max`=8 with no residue.
- `NUM_CLASS`=1 build: start then score 42 → DONE directly from LOAD, `o_idx`=0, `o_max`=42.
